// File: rtl/div_pkg.sv
// Shared divider definitions: remainder-sign FSM states, the default
// operand width and the flag bundle handed to the rounding stages.
package div_pkg;

    localparam int DIV_WIDTH = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } rem_state_t;

    typedef struct packed {
        logic positive;
        logic negative;
        logic zero;
    } rem_flags_t;

endpackage

// File: rtl/rem_sign_calc_if.sv
// Operand / flag handshake bundle for rem_sign_calc.
// master = producer of operands and consumer of flags; slave = the unit.
interface rem_sign_calc_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] n;
    logic             out_valid;
    logic             out_ready;
    logic             rem_is_positive;
    logic             rem_is_negative;
    logic             rem_is_zero;

    modport master (
        output in_valid, q, d, n, out_ready,
        input  in_ready, out_valid, rem_is_positive, rem_is_negative, rem_is_zero
    );

    modport slave (
        input  in_valid, q, d, n, out_ready,
        output in_ready, out_valid, rem_is_positive, rem_is_negative, rem_is_zero
    );

endinterface

// File: rtl/rem_addend_sel.sv
// Addend selection for the back-multiply.
// Default: radix-2, addend is d or 0 depending on one quotient bit.
// With REM_RADIX4_EN defined: radix-4, addend is 0/d/2d/3d from two quotient bits.
module rem_addend_sel
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] d,
`ifdef REM_RADIX4_EN
    input  logic [WIDTH+1:0] d3,
    input  logic [1:0]       sel,
`else
    input  logic             sel,
`endif
    output logic [WIDTH+1:0] addend
);

`ifdef REM_RADIX4_EN
    // Pick the multiple of d selected by the current quotient digit
    always_comb begin
        addend = '0;
        case (sel)
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, d};
            2'd2:    addend = {1'b0, d, 1'b0};
            default: addend = d3;
        endcase
    end
`else
    // Pass d through when the current quotient bit is set
    always_comb begin
        addend = sel ? {2'b00, d} : '0;
    end
`endif

endmodule

// File: rtl/rem_sign_calc.sv
// Remainder-sign unit: R = {n, 0} - q*d via a sequential shift-add
// multiplier, reporting the sign of R as positive/negative/zero flags.
// Default build is radix-2 (WIDTH+1 cycle latency); defining REM_RADIX4_EN
// retires two quotient bits per cycle (WIDTH/2+1 cycle latency).
module rem_sign_calc
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    rem_sign_calc_if.slave bus
);

`ifdef REM_RADIX4_EN
    localparam int BITS_PER_STEP = 2;
`else
    localparam int BITS_PER_STEP = 1;
`endif
    localparam int STEPS = WIDTH / BITS_PER_STEP;
    localparam int CNT_W = $clog2(WIDTH);
    localparam int SH_W  = CNT_W + 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    rem_state_t       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_sr_q, q_sr_d;
    logic [PW-1:0]    n_q, n_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rem_flags_t       flags_q, flags_d;
`ifdef REM_RADIX4_EN
    logic [WIDTH+1:0] d3_q, d3_d;
`endif

    logic             accept;
    logic [WIDTH+1:0] addend;
    logic [CNT_W-1:0] step;
    logic [SH_W-1:0]  shamt;
    logic [PW-1:0]    addend_sh;
    logic [PW:0]      rem;

    assign accept    = (state_q == IDLE) && bus.in_valid;
    // Step index k counts up as the counter counts down; radix-4 shifts by 2k.
    assign step      = LAST_CNT - cnt_q;
    assign shamt     = {1'b0, step} << (BITS_PER_STEP - 1);
    assign addend_sh = {{(PW - WIDTH - 2){1'b0}}, addend} << shamt;
    // One extra top bit so the borrow out of the subtraction is the sign.
    assign rem       = {1'b0, n_q} - {1'b0, acc_q};

    rem_addend_sel #(
        .WIDTH (WIDTH)
    ) u_addend_sel (
        .d      (d_q),
`ifdef REM_RADIX4_EN
        .d3     (d3_q),
        .sel    (q_sr_q[1:0]),
`else
        .sel    (q_sr_q[0]),
`endif
        .addend (addend)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = MUL;
            MUL:     if (cnt_q == '0)   state_d = CMP;
            CMP:                        state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Output logic: handshake from state, flags only visible in DONE
    always_comb begin
        bus.in_ready        = (state_q == IDLE);
        bus.out_valid       = (state_q == DONE);
        bus.rem_is_positive = (state_q == DONE) && flags_q.positive;
        bus.rem_is_negative = (state_q == DONE) && flags_q.negative;
        bus.rem_is_zero     = (state_q == DONE) && flags_q.zero;
    end

    // Datapath next values: operand capture, shift-add step, sign compare
    always_comb begin
        d_d     = d_q;
        q_sr_d  = q_sr_q;
        n_d     = n_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
`ifdef REM_RADIX4_EN
        d3_d    = d3_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d    = bus.d;
                    n_d    = {bus.n, {WIDTH{1'b0}}};
                    q_sr_d = bus.q;
                    acc_d  = '0;
                    cnt_d  = LAST_CNT;
`ifdef REM_RADIX4_EN
                    d3_d   = {2'b00, bus.d} + {1'b0, bus.d, 1'b0};
`endif
                end
            end
            MUL: begin
                acc_d  = acc_q + addend_sh;
                q_sr_d = q_sr_q >> BITS_PER_STEP;
                cnt_d  = cnt_q - 1'b1;
            end
            CMP: begin
                flags_d.negative = rem[PW];
                flags_d.zero     = (rem == '0);
                flags_d.positive = !rem[PW] && (rem != '0);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale operands.
        if (reset) begin
            d_q     <= '0;
            q_sr_q  <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
`ifdef REM_RADIX4_EN
            d3_q    <= '0;
`endif
        end else begin
            d_q     <= d_d;
            q_sr_q  <= q_sr_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
`ifdef REM_RADIX4_EN
            d3_q    <= d3_d;
`endif
        end
    end

endmodule

// File: tb/tb_rem_sign_calc.sv
// Directed + small random bench for rem_sign_calc at WIDTH=8.
module tb_rem_sign_calc;

    localparam int W = 8;
`ifdef REM_RADIX4_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif
    // Flag encoding {positive, negative, zero}
    localparam logic [2:0] F_POS  = 3'b100;
    localparam logic [2:0] F_NEG  = 3'b010;
    localparam logic [2:0] F_ZERO = 3'b001;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    rem_sign_calc_if #(.WIDTH(W)) bus ();

    rem_sign_calc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] flags();
        return {bus.rem_is_positive, bus.rem_is_negative, bus.rem_is_zero};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [7:0] q, input logic [7:0] d, input logic [7:0] n);
        logic [15:0] nn;
        logic [15:0] p;
        nn = {n, 8'h00};
        p  = 16'(q) * 16'(d);
        if (p > nn)       return F_NEG;
        else if (p == nn) return F_ZERO;
        else              return F_POS;
    endfunction

    // One operation: accept, scramble operands, wait for result, optional hold, release.
    task automatic run_op(input string tag, input logic [7:0] q, input logic [7:0] d,
                          input logic [7:0] n, input logic [2:0] exp, input int hold,
                          input bit rdy_early);
        int cycles;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.q         = q;
        bus.d         = d;
        bus.n         = n;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy_early;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.q        = ~q;
        bus.d        = ~d;
        bus.n        = ~n;
        check({tag, "_busy"}, 32'(bus.in_ready), 0);
        cycles = 0;
        while (!bus.out_valid && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(LAT));
        check({tag, "_flags"}, 32'(flags()), 32'(exp));
        check({tag, "_onehot"}, 32'($countones(flags())), 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_flags"}, 32'(flags()), 32'(exp));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 1);
        check({tag, "_post_flags"}, 32'(flags()), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rq, rd, rn;
        clk           = 1'b0;
        reset         = 1'b0;
        n_vec         = 0;
        n_err         = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.q         = '0;
        bus.d         = '0;
        bus.n         = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_flags", 32'(flags()), 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("exact",  8'h80, 8'h80, 8'h40, F_ZERO, 0, 1'b0);
        run_op("neg",    8'h81, 8'h80, 8'h40, F_NEG,  0, 1'b0);
        run_op("pos",    8'h7F, 8'h80, 8'h40, F_POS,  0, 1'b0);
        run_op("maxprod", 8'hFF, 8'hFF, 8'h00, F_NEG, 5, 1'b0);
        run_op("allzero", 8'h00, 8'h00, 8'h00, F_ZERO, 0, 1'b0);
        run_op("q0",     8'h00, 8'hFF, 8'h01, F_POS,  0, 1'b0);
        run_op("maxn",   8'hFF, 8'hFF, 8'hFF, F_POS,  0, 1'b1);
        run_op("back2back", 8'h01, 8'h01, 8'h00, F_NEG, 0, 1'b1);

        // Reset during MUL discards the operation
        @(negedge clk);
        bus.q        = 8'h81;
        bus.d        = 8'h80;
        bus.n        = 8'h40;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_flags", 32'(flags()), 0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_rst", 8'h7F, 8'h80, 8'h40, F_POS, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rq = 8'($urandom);
            rd = 8'($urandom);
            rn = 8'($urandom);
            if (i % 3 == 0) rn = 8'((16'(rq) * 16'(rd)) >> 8);
            run_op("rand", rq, rd, rn, model(rq, rd, rn), 0, (i % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rem_sign_calc.md
# rem_sign_calc

Iterative back-multiply remainder-sign unit for the divider datapath. It takes a truncated quotient candidate `q`, the divisor `d` and the dividend `n`, forms R = {n, WIDTH'b0} − q·d with a sequential shift-add multiplier, and reports the sign of R. Its flags drive the `rem_is_positive` / `rem_is_negative` inputs of the round-to-nearest-even and round-toward-zero stages. It sits between the quotient iteration and the rounding stage, using a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 28: width of q, d and n, in bits; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  q/d/n are valid.
- `in_ready`  out  1  block can accept an operand set.
- `q`  in  WIDTH  unsigned quotient candidate, including guard bits.
- `d`  in  WIDTH  unsigned divisor.
- `n`  in  WIDTH  unsigned dividend.
- `out_valid`  out  1  flags are valid.
- `out_ready`  in  1  consumer accepts the flags.
- `rem_is_positive`  out  1  R > 0.
- `rem_is_negative`  out  1  R < 0.
- `rem_is_zero`  out  1  R == 0.

## Operation
- FSM states and transitions:
  - IDLE → MUL on in_valid && in_ready.
  - MUL → CMP when the step counter expires.
  - CMP → DONE unconditionally.
  - DONE → IDLE on out_ready.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).
- On accept:
  - Latch d and {n, WIDTH'b0} into registers.
  - Load q into a shift register.
  - Clear the 2·WIDTH-bit accumulator.
  - Load the step counter with WIDTH − 1.
- MUL, radix-2, per cycle:
  - If q_sr[0] = 1, add (d << k) to the accumulator, where k is the step index.
  - Shift q_sr right by 1.
  - Decrement the counter.
  - The accumulator is 2·WIDTH bits and never overflows, since q·d < 2^(2·WIDTH).
- CMP: compute R = {1'b0, N} − {1'b0, P} as a (2·WIDTH+1)-bit signed value, then register:
  - negative = R[2·WIDTH]
  - zero = (R == 0)
  - positive = neither
- Flag outputs:
  - Exactly one flag is high while out_valid is high.
  - All flags hold stable until the out_ready handshake completes.
  - All flags are 0 outside DONE.
- In-flight operations: in_valid is ignored outside IDLE, and operand changes after acceptance have no effect.
- DONE with out_ready already high: the result completes in one DONE cycle. IDLE then accepts in the following cycle (no same-cycle turnaround).
- Reset mid-operation: the FSM returns to IDLE and the result is discarded.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - rem_is_positive, rem_is_negative, rem_is_zero = 0
  - datapath registers = 0

## Timing
- Accept edge is edge t.
- Radix-2: MUL occupies edges t+1 … t+WIDTH, CMP occupies edge t+WIDTH+1, and out_valid is high after edge t+WIDTH+1.
  - Latency from accept to out_valid is WIDTH+1 cycles.
- Radix-4 (see Configuration): MUL is WIDTH/2 cycles, and latency is WIDTH/2+1 cycles.
- Throughput: one operation per latency+2 cycles when out_ready is held high.
- No combinational path from any input to any output.

## Configuration
- Macro: `REM_RADIX4_EN`.
- Defined:
  - MUL retires 2 q bits per cycle.
  - A 3·d register is precomputed at accept.
  - The addend is selected from {0, d, 2d, 3d} by q_sr[1:0], shifted by 2k.
  - Counter loads WIDTH/2 − 1.
- Undefined: radix-2 as described above.
- Flags are identical for every input in both builds; only latency differs.

## Structure
- Package `div_pkg` holds:
  - the state enum `rem_state_t` (IDLE, MUL, CMP, DONE);
  - the default constant `DIV_WIDTH` = 28;
  - the type `rem_flags_t`, a struct {positive, negative, zero} shared with the rounding stage.
- One sub-module, `rem_addend_sel`: combinational addend selection. It produces d or 0 in radix-2, and 0/d/2d/3d in radix-4.
- The FSM, counter and accumulator stay in `rem_sign_calc`.

## Test plan
All scenarios use WIDTH=8.
- q=0x80, d=0x80, n=0x40 → rem_is_zero=1; out_valid exactly 9 cycles after accept (5 under `REM_RADIX4_EN`).
- q=0x81, d=0x80, n=0x40 → R = −0x80, so rem_is_negative=1.
- q=0x7F, d=0x80, n=0x40 → R = +0x80, so rem_is_positive=1.
- q=0xFF, d=0xFF, n=0x00 → rem_is_negative=1 (maximum product, no overflow). Then hold out_ready=0 for 5 cycles → flags stable, in_ready=0 throughout.
- Assert reset during MUL of q=0x81, d=0x80, n=0x40 → immediate in_ready=1, out_valid=0. A subsequent q=0x7F operation yields rem_is_positive=1.
- Random 10k operand sets checked against a reference model → exactly one flag set per result; radix-2 and radix-4 builds agree.
